// File: rtl/uart_rx_param.sv
// uart_rx_param -- parametrised UART receive engine (16750-style core).
//
// Receives one character per frame with OSR-times oversampling, three-sample
// majority voting per bit, false-start rejection, optional parity and one or
// two stop bits. It delivers DOUT/PE/FE/BI with a one-CLK RXFINISHED pulse.
//
// Parameters:
//   OSR          RXCLK ticks per bit (even, 8..64)
//   MAX_BITS     widest data word (5..9)
//   TIMEOUT_BITS idle bit-times before TOUT (optional feature only)
//
// Ports:
//   CLK, RST      system clock; asynchronous active-high reset
//   RXCLK         one-CLK sample enable at OSR x baud
//   RXCLEAR       synchronous abort/clear, highest priority
//   WLEN          data bits per frame (clamped to 5..MAX_BITS)
//   PEN/EPS/SP    parity enable / even parity / stick parity
//   STB           0 = one stop bit, 1 = two stop bits
//   SIN           asynchronous serial input
//   DOUT          received word, LSB-aligned, unused upper bits 0
//   PE/FE/BI      parity error / framing error / break
//   RXFINISHED    one-CLK pulse per completed frame
//   TOUT          one-CLK idle-timeout pulse
//
// Optional feature: define UART_RX_TIMEOUT_EN to build the idle-timeout
// counter. Without it TOUT is tied to 0 and the port list is unchanged.

module uart_rx_param #(
  parameter int OSR          = 16,
  parameter int MAX_BITS     = 8,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                RXCLK,
  input  logic                RXCLEAR,
  input  logic [3:0]          WLEN,
  input  logic                PEN,
  input  logic                EPS,
  input  logic                SP,
  input  logic                STB,
  input  logic                SIN,
  output logic [MAX_BITS-1:0] DOUT,
  output logic                PE,
  output logic                FE,
  output logic                BI,
  output logic                RXFINISHED,
  output logic                TOUT
);

  localparam int BCW = $clog2(OSR);
  localparam logic [BCW-1:0] S_LO   = BCW'(OSR/2 - 1);
  localparam logic [BCW-1:0] S_MID  = BCW'(OSR/2);
  localparam logic [BCW-1:0] S_HI   = BCW'(OSR/2 + 1);
  localparam logic [BCW-1:0] BC_TOP = BCW'(OSR - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP1, STOP2, BRKWAIT
  } state_t;

  state_t state, next;

  logic                s1, ssin;
  logic [BCW-1:0]      bc;
  logic [3:0]          idx;
  logic [MAX_BITS-1:0] data;
  logic                sa, sb;
  logic                par_bit;
  logic [3:0]          wlen_l;
  logic                pen_l, eps_l, sp_l, stb_l;

  logic                tick, smp, wrap, maj;
  logic                start_acc, fin;
  logic [3:0]          wlen_eff;
  logic                x, par_exp, pe_now, bi_now;

  // Two-FF synchronizer; idle line level is 1.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1   <= 1'b1;
      ssin <= 1'b1;
    end else begin
      s1   <= SIN;
      ssin <= s1;
    end
  end

  assign tick = RXCLK & ~RXCLEAR;
  assign smp  = tick && (bc == S_HI);
  assign wrap = tick && (bc == BC_TOP);
  // Third sample is the live value at the resolving tick.
  assign maj  = (sa & sb) | (sa & ssin) | (sb & ssin);

  always_comb begin
    wlen_eff = WLEN;
    if (WLEN < 4'd5)
      wlen_eff = 4'd5;
    else if (WLEN > 4'(MAX_BITS))
      wlen_eff = 4'(MAX_BITS);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next;
  end

  // The frame finishes at the mid-stop sample tick (not the wrap) so the
  // receiver is already in IDLE when the next start edge can arrive.
  always_comb begin
    next      = state;
    start_acc = 1'b0;
    fin       = 1'b0;
    if (RXCLEAR) begin
      next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (RXCLK && !ssin) begin
            next      = START;
            start_acc = 1'b1;
          end
        end
        START: begin
          if (smp && maj)  next = IDLE;
          else if (wrap)   next = DATA;
        end
        DATA: begin
          if (wrap && (idx == 4'(wlen_l - 4'd1)))
            next = pen_l ? PAR : STOP1;
        end
        PAR: begin
          if (wrap) next = STOP1;
        end
        STOP1: begin
          if (smp && (!maj || !stb_l)) begin
            fin  = 1'b1;
            next = maj ? IDLE : BRKWAIT;
          end else if (wrap) begin
            next = STOP2;
          end
        end
        STOP2: begin
          if (smp) begin
            fin  = 1'b1;
            next = maj ? IDLE : BRKWAIT;
          end
        end
        BRKWAIT: begin
          if (ssin) next = IDLE;
        end
        default: next = IDLE;
      endcase
    end
  end

  // Unreceived upper bits of data stay 0, so XOR over the whole word equals
  // XOR over the WLEN received bits.
  assign x       = ^data;
  assign par_exp = sp_l ? ~eps_l : (eps_l ? x : ~x);
  assign pe_now  = pen_l & (par_bit ^ par_exp);
  assign bi_now  = ~maj & (data == '0) & (~pen_l | ~par_bit);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bc         <= '0;
      idx        <= '0;
      data       <= '0;
      sa         <= 1'b1;
      sb         <= 1'b1;
      par_bit    <= 1'b0;
      wlen_l     <= 4'd5;
      pen_l      <= 1'b0;
      eps_l      <= 1'b0;
      sp_l       <= 1'b0;
      stb_l      <= 1'b0;
      DOUT       <= '0;
      PE         <= 1'b0;
      FE         <= 1'b0;
      BI         <= 1'b0;
      RXFINISHED <= 1'b0;
    end else if (RXCLEAR) begin
      bc         <= '0;
      idx        <= '0;
      data       <= '0;
      DOUT       <= '0;
      PE         <= 1'b0;
      FE         <= 1'b0;
      BI         <= 1'b0;
      RXFINISHED <= 1'b0;
    end else begin
      RXFINISHED <= fin;

      if (start_acc)
        bc <= '0;
      else if (tick)
        bc <= (bc == BC_TOP) ? '0 : bc + 1'b1;

      if (tick && (bc == S_LO))  sa <= ssin;
      if (tick && (bc == S_MID)) sb <= ssin;

      if (start_acc) begin
        wlen_l  <= wlen_eff;
        pen_l   <= PEN;
        eps_l   <= EPS;
        sp_l    <= SP;
        stb_l   <= STB;
        idx     <= '0;
        data    <= '0;
        par_bit <= 1'b0;
      end

      if (state == DATA) begin
        if (smp) begin
          for (int unsigned i = 0; i < MAX_BITS; i++)
            if (idx == 4'(i)) data[i] <= maj;
        end
        if (wrap) idx <= idx + 4'd1;
      end

      if ((state == PAR) && smp) par_bit <= maj;

      if (fin) begin
        DOUT <= data;
        FE   <= ~maj;
        PE   <= pe_now;
        BI   <= bi_now;
      end
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_BITS + 1);

  logic [TW-1:0] tcnt;
  logic          armed;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tcnt  <= '0;
      armed <= 1'b0;
      TOUT  <= 1'b0;
    end else if (RXCLEAR) begin
      tcnt  <= '0;
      armed <= 1'b0;
      TOUT  <= 1'b0;
    end else begin
      TOUT <= 1'b0;
      if (start_acc) begin
        tcnt  <= '0;
        armed <= 1'b0;
      end else if (fin) begin
        tcnt  <= '0;
        armed <= 1'b1;
      end else if (armed && (state == IDLE) && wrap) begin
        if (tcnt == TW'(TIMEOUT_BITS - 1)) begin
          TOUT  <= 1'b1;
          armed <= 1'b0;
          tcnt  <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end
    end
  end
`else
  assign TOUT = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Testbench for uart_rx_param: OSR=16, MAX_BITS=8, RXCLK every CLK.
// Frames are driven bit by bit; the expected result of each frame is pushed
// to a scoreboard queue and popped when RXFINISHED is seen.

module tb_uart_rx_param;

  localparam int BT = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RXCLK = 1'b1;
  logic       RXCLEAR = 1'b0;
  logic [3:0] WLEN = 4'd8;
  logic       PEN = 1'b0, EPS = 1'b0, SP = 1'b0, STB = 1'b0;
  logic       SIN = 1'b1;
  logic [7:0] DOUT;
  logic       PE, FE, BI, RXFINISHED, TOUT;

  uart_rx_param #(.OSR(16), .MAX_BITS(8), .TIMEOUT_BITS(40)) dut (
    .CLK(CLK), .RST(RST), .RXCLK(RXCLK), .RXCLEAR(RXCLEAR),
    .WLEN(WLEN), .PEN(PEN), .EPS(EPS), .SP(SP), .STB(STB), .SIN(SIN),
    .DOUT(DOUT), .PE(PE), .FE(FE), .BI(BI),
    .RXFINISHED(RXFINISHED), .TOUT(TOUT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       bi;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, failures = 0;
  int   fin_cnt = 0, exp_fin = 0, tout_cnt = 0;
  int   cyc = 0, last_fin_cyc = 0, tout_cyc = 0;
  logic prev_fin = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    cyc++;
    if (TOUT) begin
      tout_cnt++;
      tout_cyc = cyc;
    end
    if (RXFINISHED) begin
      fin_cnt++;
      last_fin_cyc = cyc;
      chk("fin_width", 32'(prev_fin), 0);
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("dout", 32'(DOUT), 32'(e.d));
        chk("pe", 32'(PE), 32'(e.pe));
        chk("fe", 32'(FE), 32'(e.fe));
        chk("bi", 32'(BI), 32'(e.bi));
      end
    end
    prev_fin = RXFINISHED;
  end

  function automatic logic par_of(input logic [8:0] d, input int n,
                                  input logic eps, input logic sp);
    logic px = 1'b0;
    for (int i = 0; i < n; i++) px ^= d[i];
    if (sp) return ~eps;
    return eps ? px : ~px;
  endfunction

  task automatic send_bits(input logic b, input int nclk);
    SIN = b;
    repeat (nclk) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [8:0] d, input int n, input logic has_par,
                            input logic pbit, input logic two_stop, input logic stop2);
    send_bits(1'b0, BT);
    for (int i = 0; i < n; i++) send_bits(d[i], BT);
    if (has_par) send_bits(pbit, BT);
    send_bits(1'b1, BT);
    if (two_stop) send_bits(stop2, BT);
    send_bits(1'b1, 2 * BT);
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic pe, input logic fe, input logic bi);
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe; e.bi = bi;
    sb.push_back(e);
    exp_fin++;
  endtask

  task automatic cfg(input logic [3:0] w, input logic p, input logic e, input logic s, input logic st);
    WLEN = w; PEN = p; EPS = e; SP = s; STB = st;
  endtask

  task automatic settle(input string tag);
    chk({tag, "_fin_cnt"}, 32'(fin_cnt), 32'(exp_fin));
    chk({tag, "_sb_empty"}, 32'(sb.size()), 0);
  endtask

  initial begin
    logic pb;
    int   t0;
    bit   seen;

    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // Reset state
    chk("rst_dout", 32'(DOUT), 0);
    chk("rst_pe", 32'(PE), 0);
    chk("rst_fe", 32'(FE), 0);
    chk("rst_bi", 32'(BI), 0);
    chk("rst_fin", 32'(RXFINISHED), 0);
    chk("rst_tout", 32'(TOUT), 0);
    send_bits(1'b1, 2 * BT);

    // 8N1 0xA5
    cfg(4'd8, 0, 0, 0, 0);
    expect_frame(8'hA5, 0, 0, 0);
    send_frame(9'h0A5, 8, 0, 0, 0, 1);
    settle("8n1");

    // 7E1 0x41 with wrong parity, then correct parity
    cfg(4'd7, 1, 1, 0, 0);
    pb = par_of(9'h041, 7, 1'b1, 1'b0);
    expect_frame(8'h41, 1, 0, 0);
    send_frame(9'h041, 7, 1, ~pb, 0, 1);
    expect_frame(8'h41, 0, 0, 0);
    send_frame(9'h041, 7, 1, pb, 0, 1);
    settle("7e1");

    // Stick parity (expected bit = ~EPS), wrong then right
    cfg(4'd8, 1, 0, 1, 0);
    expect_frame(8'h01, 1, 0, 0);
    send_frame(9'h001, 8, 1, 1'b0, 0, 1);
    cfg(4'd8, 1, 1, 1, 0);
    expect_frame(8'h01, 0, 0, 0);
    send_frame(9'h001, 8, 1, 1'b0, 0, 1);
    settle("stick");

    // False start: 5 CLK low glitch, then a real frame
    cfg(4'd8, 0, 0, 0, 0);
    send_bits(1'b0, 5);
    send_bits(1'b1, 2 * BT);
    settle("false_start");
    expect_frame(8'h3C, 0, 0, 0);
    send_frame(9'h03C, 8, 0, 0, 0, 1);
    settle("after_false");

    // WLEN clamping: 2 acts as 5, 15 acts as 8
    cfg(4'd2, 0, 0, 0, 0);
    expect_frame(8'h15, 0, 0, 0);
    send_frame(9'h015, 5, 0, 0, 0, 1);
    cfg(4'd15, 0, 0, 0, 0);
    expect_frame(8'hC3, 0, 0, 0);
    send_frame(9'h0C3, 8, 0, 0, 0, 1);
    settle("wlen_clamp");

    // 8N2 with bad second stop bit
    cfg(4'd8, 0, 0, 0, 1);
    expect_frame(8'h3C, 0, 1, 0);
    send_frame(9'h03C, 8, 0, 0, 1, 0);
    settle("8n2_fe");

    // Break: 20 bit-times low, then a normal frame
    cfg(4'd8, 0, 0, 0, 0);
    expect_frame(8'h00, 0, 1, 1);
    send_bits(1'b0, 20 * BT);
    send_bits(1'b1, 2 * BT);
    settle("break");
    expect_frame(8'h55, 0, 0, 0);
    send_frame(9'h055, 8, 0, 0, 0, 1);
    settle("after_break");

    // RXCLEAR mid data bit 4
    send_bits(1'b0, BT);
    for (int i = 0; i < 4; i++) send_bits(i[0], BT);
    send_bits(1'b1, BT / 2);
    RXCLEAR = 1'b1;
    @(negedge CLK);
    RXCLEAR = 1'b0;
    send_bits(1'b1, 2 * BT);
    settle("rxclear");
    chk("rxclear_dout", 32'(DOUT), 0);
    expect_frame(8'h09, 0, 0, 0);
    send_frame(9'h009, 8, 0, 0, 0, 1);
    settle("after_rxclear");

    // RST mid data bit 4
    send_bits(1'b0, BT);
    for (int i = 0; i < 4; i++) send_bits(i[0], BT);
    send_bits(1'b1, BT / 2);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    send_bits(1'b1, 2 * BT);
    settle("rst_mid");
    chk("rst_mid_dout", 32'(DOUT), 0);
    expect_frame(8'h09, 0, 0, 0);
    send_frame(9'h009, 8, 0, 0, 0, 1);
    settle("after_rst");

`ifdef UART_RX_TIMEOUT_EN
    t0 = tout_cnt;
    seen = 0;
    for (int i = 0; i < 45 * BT && !seen; i++) begin
      @(negedge CLK);
      if (tout_cnt != t0) seen = 1;
    end
    chk("tout_seen", 32'(seen), 1);
    chk("tout_delay", 32'((tout_cyc - last_fin_cyc >= 39 * BT) &&
                          (tout_cyc - last_fin_cyc <= 41 * BT)), 1);
    send_bits(1'b1, 2 * BT);
    chk("tout_once", 32'(tout_cnt - t0), 1);
`else
    t0 = 0;
    seen = 0;
    send_bits(1'b1, 4 * BT);
    chk("tout_tied", 32'(tout_cnt), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receive engine for the 16750-style UART core, successor to the fixed 16x / 5–8-bit receiver. It adds configurable oversampling, data width up to 9 bits, three-sample majority voting, false-start rejection and checking of the second stop bit. It sits between the line-control register and the RX FIFO, and delivers one character plus PE/FE/BI per frame.

## Interface
- OSR, 16: RXCLK ticks per bit; even, 8..64.
- MAX_BITS, 8: widest data word; 5..9.
- TIMEOUT_BITS, 40: idle bit-times before TOUT (only with UART_RX_TIMEOUT_EN).
- CLK  in  1  system clock.
- RST  in  1  reset, asynchronous, active-high.
- RXCLK  in  1  sample enable, one CLK wide, at OSR × baud.
- RXCLEAR  in  1  synchronous abort/clear.
- WLEN  in  4  data bits per frame; values <5 act as 5, values >MAX_BITS act as MAX_BITS.
- PEN, EPS, SP  in  1 each  parity enable / even parity / stick parity.
- STB  in  1  0 = one stop bit, 1 = two stop bits.
- SIN  in  1  serial input, asynchronous.
- DOUT  out  MAX_BITS  received word, LSB-aligned; unused upper bits 0.
- PE, FE, BI  out  1 each  parity error / framing error / break.
- RXFINISHED  out  1  one-CLK pulse when a frame completes.
- TOUT  out  1  one-CLK idle-timeout pulse.

## Operation
- SIN passes through a 2-FF synchronizer to give sSIN. Reset value 1.
- The bit counter bc counts 0..OSR-1 on RXCLK and wraps to 0. Samples are taken at bc = OSR/2-1, OSR/2 and OSR/2+1. The bit value is the majority of the three and is resolved at the sample tick (the RXCLK with bc = OSR/2+1).
- Frame settings (WLEN, PEN, EPS, SP, STB) are latched when a start is accepted. Changes mid-frame are ignored.
- FSM states and transitions:
  - IDLE: on an RXCLK with sSIN = 0, clear bc and go to START.
  - START: if the majority at the sample tick is 1, go to IDLE with no RXFINISHED (false start). Otherwise go to DATA at the bc wrap.
  - DATA: bits are received LSB first into DOUT[idx]. After WLEN bits, at the wrap, go to PAR if PEN = 1, else to STOP1.
  - PAR: capture the parity bit at the sample tick; go to STOP1 at the wrap.
  - STOP1: at the sample tick, a sample of 0 means FE. Finish the frame if STB = 0 or FE is set; otherwise go to STOP2 at the wrap.
  - STOP2: at the sample tick, a sample of 0 means FE. Finish the frame.
  - Finish: pulse RXFINISHED. Go to IDLE, or to BRKWAIT if FE is set. Leaving at the sample tick rather than the wrap allows resynchronisation to the next start bit.
  - BRKWAIT: stay until sSIN = 1, then go to IDLE.
- Parity: X = XOR of the WLEN data bits.
  - Expected bit = X when EPS = 1, ~X when EPS = 0.
  - With SP = 1, expected bit = ~EPS.
  - PE = received bit != expected bit. PE = 0 when PEN = 0.
- BI = FE and all WLEN data bits are 0 and (PEN = 0 or the parity bit is 0).
- DOUT, PE, FE and BI update in the same cycle RXFINISHED asserts. They hold until the next RXFINISHED, RXCLEAR or RST.
- RXCLEAR has priority over all other activity. It forces IDLE, zeros bc, the bit index, DOUT, PE, FE, BI and the timeout counter, and suppresses RXFINISHED.
- RST mid-frame has the same effect as RXCLEAR, applied asynchronously.

## Timing
- Reset values: DOUT = 0, PE = FE = BI = RXFINISHED = TOUT = 0, FSM = IDLE.
- Input latency: 2 CLK from SIN to sSIN, plus up to 1 RXCLK period to detect the start.
- Output latency: RXFINISHED and the status outputs are registered. They assert 1 CLK after the deciding RXCLK in the last stop bit.
- RXFINISHED is exactly 1 CLK wide and occurs once per frame, including break frames. A break generates no further pulses until sSIN = 1.
- Frame length: 1 + WLEN + PEN + 1 + STB bit-times, finishing at mid last-stop.
- RXCLK and RXCLEAR in the same cycle: RXCLEAR wins.

## Configuration
- UART_RX_TIMEOUT_EN defined:
  - A bit-time counter runs in IDLE, incrementing at each bc wrap, armed by RXFINISHED.
  - When it reaches TIMEOUT_BITS, TOUT pulses for 1 CLK and the counter disarms.
  - Start acceptance or RXCLEAR clears and disarms it.
- UART_RX_TIMEOUT_EN undefined: the counter is absent and TOUT is tied to 0. The port list is unchanged.

## Test plan
- 8N1, OSR = 16, RXCLK every CLK, frame 0xA5 → DOUT = 0x0A5, one RXFINISHED pulse, PE = FE = BI = 0.
- 7E1, data 0x41, parity bit sent as 1 (expected 0) → DOUT = 0x41, PE = 1. Next frame sent with correct parity → PE = 0.
- SIN low for 5 RXCLK in IDLE, then high → no RXFINISHED, FSM back in IDLE. Then frame 0x3C → DOUT = 0x3C.
- 8N2, second stop bit sent as 0 → FE = 1, BI = 0.
- 8N1, SIN low for 20 bit-times, then high, then frame 0x55:
  - Break → exactly one RXFINISHED with DOUT = 0, FE = BI = 1.
  - Following frame → DOUT = 0x55, FE = BI = 0.
- RXCLEAR pulsed in DATA bit 4 → no RXFINISHED and DOUT = 0; the following frame 0x9 is received correctly.
  - Same scenario with RST instead of RXCLEAR → same response.
  - With UART_RX_TIMEOUT_EN and TIMEOUT_BITS = 40: TOUT pulses 40 bit-times after the last RXFINISHED.
